// File: rtl/spi_slave_frame_ctrl_if.sv
// Pin-level and register-port bundle of the SPI slave frame controller.
// The slave modport is the controller's view; the master modport is its environment.
interface spi_slave_frame_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_SCK;
    logic                  i_CS_N;
    logic                  i_MOSI;
    logic [6:0]            o_ADDR;
    logic                  o_WR_EN;
    logic [DATA_WIDTH-1:0] o_WR_DATA;
    logic                  o_RD_EN;
    logic [DATA_WIDTH-1:0] i_RD_DATA;
    logic                  o_TX_START;
    logic [DATA_WIDTH-1:0] o_TX_DATA;
    logic                  o_TX_SHIFT;
    logic                  o_MISO_OE;
    logic                  o_BUSY;

    modport slave (
        input  i_SCK,
        input  i_CS_N,
        input  i_MOSI,
        input  i_RD_DATA,
        output o_ADDR,
        output o_WR_EN,
        output o_WR_DATA,
        output o_RD_EN,
        output o_TX_START,
        output o_TX_DATA,
        output o_TX_SHIFT,
        output o_MISO_OE,
        output o_BUSY
    );

    modport master (
        output i_SCK,
        output i_CS_N,
        output i_MOSI,
        output i_RD_DATA,
        input  o_ADDR,
        input  o_WR_EN,
        input  o_WR_DATA,
        input  o_RD_EN,
        input  o_TX_START,
        input  o_TX_DATA,
        input  o_TX_SHIFT,
        input  o_MISO_OE,
        input  o_BUSY
    );
endinterface

// File: rtl/spi_slave_frame_ctrl.sv
// SPI mode-0 slave frame controller: synchronises SCK/CS_N/MOSI, decodes a command byte plus
// data word, drives the register-file port and feeds the MISO shift-out stage on reads.
module spi_slave_frame_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    spi_slave_frame_ctrl_if.slave bus
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_WAIT,
        RD_LOAD,
        RD_XFER,
        DONE
    } state_t;

    logic [SYNC_STAGES-1:0] sckSync_q;
    logic [SYNC_STAGES-1:0] csSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic                   sckPrev_q;
    logic                   csPrev_q;
    logic                   riseStb_q;
    logic                   fallStb_q;
    logic                   sckS;
    logic                   csS;
    logic                   mosiS;
    logic                   csFall;

    state_t                 state_q, state_d;
    logic [CW-1:0]          bitCnt_q, bitCnt_d;
    logic [DATA_WIDTH-2:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  shiftIn;
    logic [6:0]             addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wrData_q, wrData_d;
    logic                   wrEn_q, wrEn_d;
    logic                   rdEn_q, rdEn_d;
    logic                   readFrame_q, readFrame_d;
    logic                   rdLatch_q;
    logic                   txStart_q;
    logic [DATA_WIDTH-1:0]  txData_q;
    logic                   txShift;

    assign sckS    = sckSync_q[SYNC_STAGES-1];
    assign csS     = csSync_q[SYNC_STAGES-1];
    assign mosiS   = mosiSync_q[SYNC_STAGES-1];
    assign csFall  = csPrev_q & ~csS;
    assign shiftIn = {shift_q, mosiS};

    // Strobes are registered so they land SYNC_STAGES+1 cycles after the pin edge.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            sckSync_q  <= '0;
            csSync_q   <= '1;
            mosiSync_q <= '0;
            sckPrev_q  <= 1'b0;
            csPrev_q   <= 1'b1;
            riseStb_q  <= 1'b0;
            fallStb_q  <= 1'b0;
        end else begin
            sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], bus.i_SCK};
            csSync_q   <= {csSync_q[SYNC_STAGES-2:0], bus.i_CS_N};
            mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], bus.i_MOSI};
            sckPrev_q  <= sckS;
            csPrev_q   <= csS;
            riseStb_q  <= sckS & ~sckPrev_q;
            fallStb_q  <= ~sckS & sckPrev_q;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            wrData_q    <= '0;
            wrEn_q      <= 1'b0;
            rdEn_q      <= 1'b0;
            readFrame_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            wrData_q    <= wrData_d;
            wrEn_q      <= wrEn_d;
            rdEn_q      <= rdEn_d;
            readFrame_q <= readFrame_d;
        end
    end

    // Read-word pipeline runs independently of the FSM so an issued read is never retracted.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            rdLatch_q <= 1'b0;
            txStart_q <= 1'b0;
            txData_q  <= '0;
        end else begin
            rdLatch_q <= rdEn_q;
            txStart_q <= rdLatch_q;
            if (rdLatch_q) begin
                txData_q <= bus.i_RD_DATA;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        wrData_d    = wrData_q;
        wrEn_d      = 1'b0;
        rdEn_d      = 1'b0;
        readFrame_d = readFrame_q;
        txShift     = 1'b0;

        case (state_q)
            IDLE: begin
                bitCnt_d    = '0;
                shift_d     = '0;
                readFrame_d = 1'b0;
                if (csFall) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (riseStb_q) begin
                    shift_d  = shiftIn[DATA_WIDTH-2:0];
                    bitCnt_d = bitCnt_q + CW'(1);
                    if (bitCnt_q == CW'(7)) begin
                        addr_d   = shiftIn[6:0];
                        bitCnt_d = '0;
                        if (shiftIn[7]) begin
                            state_d = WR_DATA;
                        end else begin
                            rdEn_d      = 1'b1;
                            readFrame_d = 1'b1;
                            state_d     = RD_WAIT;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (riseStb_q) begin
                    shift_d  = shiftIn[DATA_WIDTH-2:0];
                    bitCnt_d = bitCnt_q + CW'(1);
                    if (bitCnt_q == CW'(DATA_WIDTH - 1)) begin
                        wrData_d = shiftIn;
                        wrEn_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            RD_WAIT: begin
                if (rdLatch_q) begin
                    state_d = RD_LOAD;
                end
            end
            // The load already presents the MSB, so the first fall only arms shifting.
            RD_LOAD: begin
                if (fallStb_q) begin
                    state_d = RD_XFER;
                end
            end
            RD_XFER: begin
                txShift = fallStb_q;
                if (riseStb_q) begin
                    bitCnt_d = bitCnt_q + CW'(1);
                    if (bitCnt_q == CW'(DATA_WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (csS) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Chip-select release aborts the frame and takes priority over a coincident bit.
        if ((state_q != IDLE) && csS) begin
            state_d     = IDLE;
            bitCnt_d    = '0;
            shift_d     = shift_q;
            addr_d      = addr_q;
            wrData_d    = wrData_q;
            wrEn_d      = 1'b0;
            rdEn_d      = 1'b0;
            readFrame_d = 1'b0;
            txShift     = 1'b0;
        end
    end

    assign bus.o_ADDR     = addr_q;
    assign bus.o_WR_EN    = wrEn_q;
    assign bus.o_WR_DATA  = wrData_q;
    assign bus.o_RD_EN    = rdEn_q;
    assign bus.o_TX_START = txStart_q;
    assign bus.o_TX_DATA  = txData_q;
    assign bus.o_TX_SHIFT = txShift;
    assign bus.o_MISO_OE  = readFrame_q && (state_q != IDLE);
    assign bus.o_BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_frame_ctrl.sv
// Directed bench for spi_slave_frame_ctrl: bit-banged SPI frames with hand-computed results
// checked by immediate assertions.
module tb_spi_slave_frame_ctrl;

    localparam int DW   = 32;
    localparam int HALF = 6;

    logic i_CLK = 1'b0;
    logic i_RST = 1'b1;

    spi_slave_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    spi_slave_frame_ctrl #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(2)
    ) dut (
        .i_CLK(i_CLK),
        .i_RST(i_RST),
        .bus  (bus)
    );

    always #5 i_CLK = ~i_CLK;

    int cyc = 0;
    always @(posedge i_CLK) cyc <= cyc + 1;

    // Register-file stand-in: read word is valid only in the cycle after the read strobe.
    function automatic logic [DW-1:0] regModel(input logic [6:0] a);
        case (a)
            7'h03:   return 32'h12345678;
            7'h10:   return 32'hCAFEF00D;
            default: return {25'h0, a};
        endcase
    endfunction

    always @(posedge i_CLK) begin
        bus.i_RD_DATA <= bus.o_RD_EN ? regModel(bus.o_ADDR) : 32'hBAD0BAD0;
    end

    // Event counters observed on the falling clock edge, away from the active edge.
    int            wrCnt = 0, rdCnt = 0, startCnt = 0, shiftCnt = 0, oeCnt = 0;
    int            startCyc = 0, shiftAtStart = 0;
    logic [6:0]    wrAddr = '0, rdAddr = '0;
    logic [DW-1:0] wrData = '0;

    always @(negedge i_CLK) begin
        if (bus.o_WR_EN) begin
            wrCnt  = wrCnt + 1;
            wrAddr = bus.o_ADDR;
            wrData = bus.o_WR_DATA;
        end
        if (bus.o_RD_EN) begin
            rdCnt  = rdCnt + 1;
            rdAddr = bus.o_ADDR;
        end
        if (bus.o_TX_START) begin
            startCnt     = startCnt + 1;
            startCyc     = cyc;
            shiftAtStart = shiftCnt;
        end
        if (bus.o_TX_SHIFT) shiftCnt = shiftCnt + 1;
        if (bus.o_MISO_OE)  oeCnt    = oeCnt + 1;
    end

    int   nAsserts = 0;
    int   nFail    = 0;
    int   lastRiseCyc = 0, rise8Cyc = 0;
    logic doneOe = 1'b0, doneBusy = 1'b0;
    int   wrBase, rdBase, startBase, shiftBase, oeBase;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spiBit(input logic b);
        bus.i_MOSI = b;
        repeat (HALF) @(negedge i_CLK);
        bus.i_SCK   = 1'b1;
        lastRiseCyc = cyc;
        repeat (HALF) @(negedge i_CLK);
        bus.i_SCK = 1'b0;
    endtask

    // One frame: command byte, nData data bits MSB first, extra junk bits, then CS_N high for gap cycles.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [DW-1:0] data,
                                 input int nData, input int extra, input int gap);
        bus.i_CS_N = 1'b0;
        repeat (4) @(negedge i_CLK);
        for (int i = 7; i >= 0; i--) spiBit(cmd[i]);
        rise8Cyc = lastRiseCyc;
        for (int i = 0; i < nData; i++) spiBit(data[DW-1-i]);
        for (int i = 0; i < extra; i++) spiBit(i[0]);
        repeat (4) @(negedge i_CLK);
        doneOe     = bus.o_MISO_OE;
        doneBusy   = bus.o_BUSY;
        bus.i_CS_N = 1'b1;
        repeat (gap) @(negedge i_CLK);
    endtask

    task automatic snapshot();
        wrBase    = wrCnt;
        rdBase    = rdCnt;
        startBase = startCnt;
        shiftBase = shiftCnt;
        oeBase    = oeCnt;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " addr"},    bus.o_ADDR, 0);
        checkOutput({tag, " wr_en"},   bus.o_WR_EN, 0);
        checkOutput({tag, " wr_data"}, bus.o_WR_DATA, 0);
        checkOutput({tag, " rd_en"},   bus.o_RD_EN, 0);
        checkOutput({tag, " tx_start"},bus.o_TX_START, 0);
        checkOutput({tag, " tx_data"}, bus.o_TX_DATA, 0);
        checkOutput({tag, " tx_shift"},bus.o_TX_SHIFT, 0);
        checkOutput({tag, " miso_oe"}, bus.o_MISO_OE, 0);
        checkOutput({tag, " busy"},    bus.o_BUSY, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.i_SCK  = 1'b0;
        bus.i_CS_N = 1'b1;
        bus.i_MOSI = 1'b0;

        $display("[TB] reset state");
        repeat (3) @(negedge i_CLK);
        checkAllZero("reset");
        i_RST = 1'b0;
        @(negedge i_CLK);
        checkAllZero("post-release");
        repeat (4) @(negedge i_CLK);

        $display("[TB] write frame 0x85 / 0xDEADBEEF");
        snapshot();
        applyStimulus(8'h85, 32'hDEADBEEF, 32, 0, 8);
        checkOutput("wr count",       wrCnt - wrBase, 1);
        checkOutput("wr addr",        wrAddr, 7'h05);
        checkOutput("wr data",        wrData, 32'hDEADBEEF);
        checkOutput("wr no rd_en",    rdCnt - rdBase, 0);
        checkOutput("wr no tx_start", startCnt - startBase, 0);
        checkOutput("wr no miso_oe",  oeCnt - oeBase, 0);
        checkOutput("wr busy in done", doneBusy, 1);
        checkOutput("wr idle after",  bus.o_BUSY, 0);

        $display("[TB] read frame 0x03");
        snapshot();
        applyStimulus(8'h03, 32'h0, 32, 0, 8);
        checkOutput("rd count",          rdCnt - rdBase, 1);
        checkOutput("rd addr",           rdAddr, 7'h03);
        checkOutput("rd tx_start count", startCnt - startBase, 1);
        checkOutput("rd tx_start delay", startCyc - rise8Cyc, 6);
        checkOutput("rd tx_data",        bus.o_TX_DATA, 32'h12345678);
        checkOutput("rd shifts before load", shiftAtStart - shiftBase, 0);
        checkOutput("rd shift count",    shiftCnt - shiftBase, 31);
        checkOutput("rd no wr_en",       wrCnt - wrBase, 0);
        checkOutput("rd oe in done",     doneOe, 1);
        checkOutput("rd oe after",       bus.o_MISO_OE, 0);
        checkOutput("rd idle after",     bus.o_BUSY, 0);

        $display("[TB] aborted write 0x8A + 20 bits");
        snapshot();
        applyStimulus(8'h8A, 32'hFFFFFFFF, 20, 0, 0);
        for (int i = 0; i < 3 && bus.o_BUSY; i++) @(negedge i_CLK);
        checkOutput("abort busy drop", bus.o_BUSY, 0);
        repeat (6) @(negedge i_CLK);
        checkOutput("abort no wr_en", wrCnt - wrBase, 0);
        snapshot();
        applyStimulus(8'h8A, 32'h0BADCAFE, 32, 0, 8);
        checkOutput("post-abort wr count", wrCnt - wrBase, 1);
        checkOutput("post-abort wr addr",  wrAddr, 7'h0A);
        checkOutput("post-abort wr data",  wrData, 32'h0BADCAFE);

        $display("[TB] reset mid-frame");
        snapshot();
        bus.i_CS_N = 1'b0;
        repeat (4) @(negedge i_CLK);
        for (int i = 7; i >= 0; i--) spiBit(i == 7 || i == 6);
        for (int i = 0; i < 4; i++) spiBit(1'b1);
        #2 i_RST = 1'b1;
        #1 checkAllZero("mid-frame reset");
        bus.i_SCK  = 1'b0;
        bus.i_CS_N = 1'b1;
        repeat (3) @(negedge i_CLK);
        i_RST = 1'b0;
        repeat (4) @(negedge i_CLK);
        checkOutput("reset no wr_en", wrCnt - wrBase, 0);
        applyStimulus(8'hFF, 32'h00000001, 32, 0, 8);
        checkOutput("post-reset wr count", wrCnt - wrBase, 1);
        checkOutput("post-reset wr addr",  wrAddr, 7'h7F);
        checkOutput("post-reset wr data",  wrData, 32'h00000001);

        $display("[TB] overlong write frame");
        snapshot();
        applyStimulus(8'h81, 32'hA5A5A5A5, 32, 8, 8);
        checkOutput("overlong wr count", wrCnt - wrBase, 1);
        checkOutput("overlong wr addr",  wrAddr, 7'h01);
        checkOutput("overlong wr data",  wrData, 32'hA5A5A5A5);

        $display("[TB] back-to-back read then write");
        snapshot();
        applyStimulus(8'h10, 32'h0, 32, 0, 3);
        applyStimulus(8'h90, 32'h5555AAAA, 32, 0, 8);
        checkOutput("b2b rd count", rdCnt - rdBase, 1);
        checkOutput("b2b wr count", wrCnt - wrBase, 1);
        checkOutput("b2b rd addr",  rdAddr, 7'h10);
        checkOutput("b2b wr addr",  wrAddr, 7'h10);
        checkOutput("b2b tx_data",  bus.o_TX_DATA, 32'hCAFEF00D);
        checkOutput("b2b wr data",  wrData, 32'h5555AAAA);
        checkOutput("b2b shifts",   shiftCnt - shiftBase, 31);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
